// File: rtl/grover_diffuse.sv
// Streaming Grover diffusion: buffers a NUM_SAMPLE vector, then emits 2*mean - a[i] in index order.
// Build option GROVER_DIFFUSE_SAT_EN: saturate the result instead of two's-complement wrap.
module grover_diffuse #(
   parameter int NUM_BIT = 3,
   parameter int WIDTH   = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   in_data,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [WIDTH-1:0]   out_data,
   output logic [NUM_BIT-1:0] out_index,
   output logic               out_last
);
   localparam int NUM_SAMPLE = 2 ** NUM_BIT;
   localparam int SW         = WIDTH + NUM_BIT;
   localparam int DW         = WIDTH + 2;

   localparam logic [1:0] LOAD = 2'd0;
   localparam logic [1:0] MEAN = 2'd1;
   localparam logic [1:0] EMIT = 2'd2;

   localparam logic [NUM_BIT-1:0] CNT_MAX = NUM_BIT'(NUM_SAMPLE - 1);
   localparam logic signed [DW-1:0] SAT_MAX = {3'b000, {(WIDTH-1){1'b1}}};
   localparam logic signed [DW-1:0] SAT_MIN = {3'b111, {(WIDTH-1){1'b0}}};

   logic [1:0]               state_q, state_d;
   logic [NUM_BIT-1:0]       cnt_q, cnt_d;
   logic signed [SW-1:0]     sum_q, sum_d;
   logic signed [WIDTH-1:0]  mean_q, mean_d;
   logic [WIDTH-1:0]         buf_q [NUM_SAMPLE];
   logic [WIDTH-1:0]         buf_d [NUM_SAMPLE];

   logic                     in_fire, out_fire;
   logic signed [SW-1:0]     sum_shift;
   logic signed [DW-1:0]     mean_x, samp_x, diff;
   logic [WIDTH-1:0]         diff_f;

   assign in_ready  = (state_q == LOAD);
   assign out_valid = (state_q == EMIT);
   assign in_fire   = in_valid & in_ready;
   assign out_fire  = out_valid & out_ready;
   assign sum_shift = sum_q >>> NUM_BIT;

   // Difference is formed at WIDTH+2 bits so 2*mean - a never overflows before f().
   always_comb begin
      mean_x = {{2{mean_q[WIDTH-1]}}, mean_q};
      samp_x = {{2{buf_q[cnt_q][WIDTH-1]}}, buf_q[cnt_q]};
      diff   = (mean_x <<< 1) - samp_x;
`ifdef GROVER_DIFFUSE_SAT_EN
      if (diff > SAT_MAX)      diff_f = SAT_MAX[WIDTH-1:0];
      else if (diff < SAT_MIN) diff_f = SAT_MIN[WIDTH-1:0];
      else                     diff_f = diff[WIDTH-1:0];
`else
      diff_f = diff[WIDTH-1:0];
`endif
   end

   // Outputs are forced to zero outside EMIT so they sit at their reset values.
   assign out_data  = out_valid ? diff_f : '0;
   assign out_index = out_valid ? cnt_q : '0;
   assign out_last  = out_valid && (cnt_q == CNT_MAX);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      sum_d   = sum_q;
      mean_d  = mean_q;
      buf_d   = buf_q;
      case (state_q)
         LOAD: begin
            if (in_fire) begin
               buf_d[cnt_q] = in_data;
               sum_d        = sum_q + {{NUM_BIT{in_data[WIDTH-1]}}, in_data};
               if (cnt_q == CNT_MAX) begin
                  cnt_d   = '0;
                  state_d = MEAN;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         MEAN: begin
            mean_d  = sum_shift[WIDTH-1:0];
            state_d = EMIT;
         end
         EMIT: begin
            if (out_fire) begin
               if (cnt_q == CNT_MAX) begin
                  cnt_d   = '0;
                  sum_d   = '0;
                  state_d = LOAD;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         default: state_d = LOAD;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= LOAD;
         cnt_q   <= '0;
         sum_q   <= '0;
         mean_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         sum_q   <= sum_d;
         mean_q  <= mean_d;
      end
   end

   // Sample buffer carries no reset; its contents are irrelevant until refilled.
   always_ff @(posedge clk) begin
      buf_q <= buf_d;
   end
endmodule

// File: tb/tb_grover_diffuse.sv
// Bench for grover_diffuse: random and directed vectors checked against an arithmetic reference.
module tb_grover_diffuse;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [7:0] in_data = '0;
   logic       out_valid;
   logic       out_ready = 1'b0;
   logic [7:0] out_data;
   logic [2:0] out_index;
   logic       out_last;

   int total = 0;
   int bad   = 0;

   grover_diffuse #(.NUM_BIT(3), .WIDTH(8)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_index(out_index), .out_last(out_last)
   );

   always #5 clk = ~clk;

   // Reference: floor mean of the vector, then 2*mean - a reduced to 8 bits.
   function automatic int ref_out(input int a[8], input int i);
      int s, m, d;
      s = 0;
      for (int k = 0; k < 8; k++) s += a[k];
      m = (s >= 0) ? s / 8 : -((-s + 7) / 8);
      d = 2 * m - a[i];
`ifdef GROVER_DIFFUSE_SAT_EN
      if (d > 127) d = 127;
      if (d < -128) d = -128;
`else
      d = ((d % 256) + 256) % 256;
      if (d > 127) d -= 256;
`endif
      return d;
   endfunction

   task automatic push_vec(input int a[8]);
      int cyc;
      for (int i = 0; i < 8; i++) begin
         in_valid = 1'b1;
         in_data  = 8'(a[i]);
         cyc = 0;
         while (!in_ready && cyc < 100) begin
            @(posedge clk); #1; cyc++;
         end
         total++;
         if (!in_ready) begin
            bad++;
            $display("FAIL push_timeout idx=%0d in_ready=%b want 1", i, in_ready);
         end
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
   endtask

   task automatic pull_vec(input int a[8], input bit rnd, input bit hold, input int n);
      int got, cyc, e;
      logic [7:0] pd;
      bit stall;
      got = 0; cyc = 0; stall = 0; pd = '0;
      while (got < n && cyc < 300) begin
         out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         if (hold) begin in_valid = 1'b1; in_data = 8'($urandom); end
         if (out_valid) begin
            e = ref_out(a, got);
            total++;
            if (stall && out_data !== pd) begin
               bad++;
               $display("FAIL stall_hold data=%0d want %0d", out_data, pd);
            end
            total++;
            if (out_index !== 3'(got)) begin
               bad++;
               $display("FAIL out_index got=%0d want %0d", out_index, got);
            end
            total++;
            if ($signed(out_data) !== e) begin
               bad++;
               $display("FAIL out_data idx=%0d got=%0d want %0d", got, $signed(out_data), e);
            end
            total++;
            if (out_last !== (got == 7)) begin
               bad++;
               $display("FAIL out_last idx=%0d got=%b want %b", got, out_last, got == 7);
            end
            total++;
            if (in_ready !== 1'b0) begin
               bad++;
               $display("FAIL in_ready_emit got=%b want 0", in_ready);
            end
            pd = out_data;
            stall = !out_ready;
            if (out_ready) got++;
         end
         @(posedge clk); #1; cyc++;
      end
      if (hold) in_valid = 1'b0;
      total++;
      if (got < n) begin
         bad++;
         $display("FAIL pull_timeout outputs=%0d want %0d", got, n);
      end
      if (n == 8) begin
         total++;
         if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL vector_end in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
         end
      end
   endtask

   task automatic check_reset_vals(input string tag);
      total++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== 8'd0 ||
          out_index !== 3'd0 || out_last !== 1'b0) begin
         bad++;
         $display("FAIL %s rdy=%b vld=%b data=%0d idx=%0d last=%b want 1/0/0/0/0",
                  tag, in_ready, out_valid, out_data, out_index, out_last);
      end
   endtask

   task automatic rand_vec(output int a[8]);
      for (int i = 0; i < 8; i++) a[i] = int'($urandom_range(0, 255)) - 128;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #12;
      check_reset_vals("reset_state");
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_oracle();
      int a[8];
      for (int i = 0; i < 8; i++) a[i] = (i == 5) ? -32 : 32;
      out_ready = 1'b0;
      push_vec(a);
      total++;
      if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
         bad++;
         $display("FAIL latency_mean out_valid=%b in_ready=%b want 0/0", out_valid, in_ready);
      end
      @(posedge clk); #1;
      total++;
      if (out_valid !== 1'b1) begin
         bad++;
         $display("FAIL latency_emit out_valid=%b want 1", out_valid);
      end
      pull_vec(a, 1'b0, 1'b0, 8);
      out_ready = 1'b0;
   endtask

   task automatic test_floor();
      int a[8];
      for (int i = 0; i < 8; i++) a[i] = (i == 0) ? -1 : 0;
      push_vec(a);
      pull_vec(a, 1'b0, 1'b0, 8);
      out_ready = 1'b0;
   endtask

   task automatic test_overflow();
      int a[8];
      for (int i = 0; i < 8; i++) a[i] = (i == 0) ? -128 : 127;
      push_vec(a);
      pull_vec(a, 1'b0, 1'b0, 8);
      out_ready = 1'b0;
   endtask

   task automatic test_backpressure();
      int a[8];
      for (int r = 0; r < 4; r++) begin
         rand_vec(a);
         push_vec(a);
         pull_vec(a, 1'b1, 1'b1, 8);
      end
      out_ready = 1'b0;
   endtask

   task automatic test_reset_mid();
      int a[8], b[8];
      rand_vec(a);
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1; in_data = 8'(a[i]);
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      rst_n = 1'b0; #1;
      check_reset_vals("reset_mid_load");
      @(posedge clk); #1;
      rst_n = 1'b1;
      rand_vec(b);
      push_vec(b);
      pull_vec(b, 1'b0, 1'b0, 3);
      rst_n = 1'b0; #1;
      check_reset_vals("reset_mid_emit");
      out_ready = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      rand_vec(a);
      push_vec(a);
      pull_vec(a, 1'b1, 1'b0, 8);
      out_ready = 1'b0;
   endtask

   task automatic test_back_to_back();
      int a[8], b[8];
      rand_vec(a);
      rand_vec(b);
      out_ready = 1'b1;
      push_vec(a);
      fork
         pull_vec(a, 1'b0, 1'b0, 8);
         push_vec(b);
      join
      pull_vec(b, 1'b0, 1'b0, 8);
      out_ready = 1'b0;
   endtask

   initial begin
      test_reset();
      test_oracle();
      test_floor();
      test_overflow();
      test_backpressure();
      test_reset_mid();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
